// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared arbiter state and port identifiers
package mem_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_RD_WAIT} arb_state_t;
  typedef enum logic [1:0] {PORT_BL, PORT_IF, PORT_DM} arb_port_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports (bl, if, dm) and RAM side of the arbiter
// Per requester: req/we/be/addr/wdata in, gnt/rvalid/rdata out.
// RAM side: read_req/read_addr out, read_data in, write_enable/byte_enable/write_addr/write_data out.
// slave = arbiter view, master = requester/RAM view.
interface mem_arbiter_if #(parameter int ADDR_WIDTH = 31, parameter int DATA_WIDTH = 31);
  logic                i_bl_req, i_bl_we, o_bl_gnt, o_bl_rvalid;
  logic [3:0]          i_bl_be;
  logic [ADDR_WIDTH:0] i_bl_addr;
  logic [DATA_WIDTH:0] i_bl_wdata, o_bl_rdata;
  logic                i_if_req, i_if_we, o_if_gnt, o_if_rvalid;
  logic [3:0]          i_if_be;
  logic [ADDR_WIDTH:0] i_if_addr;
  logic [DATA_WIDTH:0] i_if_wdata, o_if_rdata;
  logic                i_dm_req, i_dm_we, o_dm_gnt, o_dm_rvalid;
  logic [3:0]          i_dm_be;
  logic [ADDR_WIDTH:0] i_dm_addr;
  logic [DATA_WIDTH:0] i_dm_wdata, o_dm_rdata;
  logic                o_read_req, o_write_enable;
  logic [ADDR_WIDTH:0] o_read_addr, o_write_addr;
  logic [DATA_WIDTH:0] i_read_data, o_write_data;
  logic [3:0]          o_byte_enable;
  modport slave (
    input  i_bl_req, i_bl_we, i_bl_be, i_bl_addr, i_bl_wdata,
    input  i_if_req, i_if_we, i_if_be, i_if_addr, i_if_wdata,
    input  i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata, i_read_data,
    output o_bl_gnt, o_bl_rvalid, o_bl_rdata, o_if_gnt, o_if_rvalid, o_if_rdata,
    output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    output o_read_req, o_read_addr, o_write_enable, o_byte_enable, o_write_addr, o_write_data
  );
  modport master (
    output i_bl_req, i_bl_we, i_bl_be, i_bl_addr, i_bl_wdata,
    output i_if_req, i_if_we, i_if_be, i_if_addr, i_if_wdata,
    output i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata, i_read_data,
    input  o_bl_gnt, o_bl_rvalid, o_bl_rdata, o_if_gnt, o_if_rvalid, o_if_rdata,
    input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    input  o_read_req, o_read_addr, o_write_enable, o_byte_enable, o_write_addr, o_write_data
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-input round-robin picker
// i_req[0]/i_req[1]: requests a/b; i_last_b: b was granted last; o_gnt: one-hot grant.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last_b,
  output logic [1:0] o_gnt
);
  assign o_gnt[0] = i_req[0] && (!i_req[1] || i_last_b);
  assign o_gnt[1] = i_req[1] && (!i_req[0] || !i_last_b);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-RAM arbiter for bios loader, instruction fetch and data memory
// clk/rst_n: clock, async active-low reset; i_booted: 0 loader owns RAM, 1 CPU ports own RAM;
// o_busy: read outstanding; bus: requester and RAM signals (slave modport).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(parameter int ADDR_WIDTH = 31, parameter int DATA_WIDTH = 31) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_booted,
  output logic o_busy,
  mem_arbiter_if.slave bus
);
  arb_state_t          r_state;
  arb_port_t           r_last, r_owner, w_sel;
  logic                w_idle, w_gnt_bl, w_any, w_we, w_rd;
  logic [1:0]          w_pick;
  logic [3:0]          w_be;
  logic [ADDR_WIDTH:0] w_addr;
  logic [DATA_WIDTH:0] w_wdata;
  // rst_n gates grants so outputs drop the moment reset asserts
  assign w_idle   = rst_n && r_state == ARB_IDLE;
  assign w_gnt_bl = w_idle && !i_booted && bus.i_bl_req;
  rr_pick2 u_pick (
    .i_req    ({w_idle && i_booted && bus.i_dm_req, w_idle && i_booted && bus.i_if_req}),
    .i_last_b (r_last == PORT_DM),
    .o_gnt    (w_pick)
  );
  assign w_any   = w_gnt_bl || |w_pick;
  assign w_sel   = w_pick[0] ? PORT_IF : w_pick[1] ? PORT_DM : PORT_BL;
  assign w_we    = w_sel == PORT_IF ? bus.i_if_we    : w_sel == PORT_DM ? bus.i_dm_we    : bus.i_bl_we;
  assign w_be    = w_sel == PORT_IF ? bus.i_if_be    : w_sel == PORT_DM ? bus.i_dm_be    : bus.i_bl_be;
  assign w_addr  = w_sel == PORT_IF ? bus.i_if_addr  : w_sel == PORT_DM ? bus.i_dm_addr  : bus.i_bl_addr;
  assign w_wdata = w_sel == PORT_IF ? bus.i_if_wdata : w_sel == PORT_DM ? bus.i_dm_wdata : bus.i_bl_wdata;
  assign bus.o_bl_gnt       = w_gnt_bl;
  assign bus.o_if_gnt       = w_pick[0];
  assign bus.o_dm_gnt       = w_pick[1];
  assign bus.o_read_req     = w_any && !w_we;
  assign bus.o_read_addr    = bus.o_read_req ? w_addr : '0;
  assign bus.o_write_enable = w_any && w_we;
  assign bus.o_byte_enable  = bus.o_write_enable ? w_be : 4'b0;
  assign bus.o_write_addr   = bus.o_write_enable ? w_addr : '0;
  assign bus.o_write_data   = bus.o_write_enable ? w_wdata : '0;
  assign w_rd               = r_state == ARB_RD_WAIT;
  assign o_busy             = w_rd;
  assign bus.o_bl_rvalid    = w_rd && r_owner == PORT_BL;
  assign bus.o_if_rvalid    = w_rd && r_owner == PORT_IF;
  assign bus.o_dm_rvalid    = w_rd && r_owner == PORT_DM;
  assign bus.o_bl_rdata     = bus.i_read_data;
  assign bus.o_if_rdata     = bus.i_read_data;
  assign bus.o_dm_rdata     = bus.i_read_data;
  // last_grant only tracks the if/dm pair; loader grants leave it untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_last  <= PORT_DM;
      r_owner <= PORT_BL;
    end else if (w_rd) r_state <= ARB_IDLE;
    else if (w_any) begin
      if (w_sel != PORT_BL) r_last <= w_sel;
      if (!w_we) begin
        r_state <= ARB_RD_WAIT;
        r_owner <= w_sel;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
  logic clk = 0, rst_n = 0, booted = 0, busy;
  int checks = 0, failures = 0;
  logic        req[3], we[3];
  logic [3:0]  be[3];
  logic [31:0] addr[3], wdata[3], rdin;
  // model: read outstanding, its owner (0 bl,1 if,2 dm), last CPU port granted
  bit m_busy = 0;
  int m_owner = 0, m_last = 2;
  mem_arbiter_if #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) bus ();
  mem_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk(clk), .rst_n(rst_n), .i_booted(booted), .o_busy(busy), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      req[i] = 0; we[i] = 0; be[i] = 0; addr[i] = 0; wdata[i] = 0;
    end
  endtask

  task automatic apply();
    bus.i_bl_req = req[0]; bus.i_bl_we = we[0]; bus.i_bl_be = be[0]; bus.i_bl_addr = addr[0]; bus.i_bl_wdata = wdata[0];
    bus.i_if_req = req[1]; bus.i_if_we = we[1]; bus.i_if_be = be[1]; bus.i_if_addr = addr[1]; bus.i_if_wdata = wdata[1];
    bus.i_dm_req = req[2]; bus.i_dm_we = we[2]; bus.i_dm_be = be[2]; bus.i_dm_addr = addr[2]; bus.i_dm_wdata = wdata[2];
    bus.i_read_data = rdin;
  endtask

  // called one time unit after a rising edge; checks mid-cycle, then advances the model at the edge
  task automatic cyc(input string tag);
    int g;
    bit rr, ww;
    apply();
    if (!rst_n) begin m_busy = 0; m_owner = 0; m_last = 2; end
    g = -1;
    if (rst_n && !m_busy) begin
      if (!booted) g = req[0] ? 0 : -1;
      else if (req[1] && req[2]) g = (m_last == 2) ? 1 : 2;
      else if (req[1]) g = 1;
      else if (req[2]) g = 2;
    end
    rr = g >= 0 && !we[g >= 0 ? g : 0];
    ww = g >= 0 && we[g >= 0 ? g : 0];
    #4;
    chk({tag, "_bl_gnt"}, bus.o_bl_gnt, g == 0);
    chk({tag, "_if_gnt"}, bus.o_if_gnt, g == 1);
    chk({tag, "_dm_gnt"}, bus.o_dm_gnt, g == 2);
    chk({tag, "_bl_rvalid"}, bus.o_bl_rvalid, m_busy && m_owner == 0);
    chk({tag, "_if_rvalid"}, bus.o_if_rvalid, m_busy && m_owner == 1);
    chk({tag, "_dm_rvalid"}, bus.o_dm_rvalid, m_busy && m_owner == 2);
    chk({tag, "_bl_rdata"}, bus.o_bl_rdata, rdin);
    chk({tag, "_if_rdata"}, bus.o_if_rdata, rdin);
    chk({tag, "_dm_rdata"}, bus.o_dm_rdata, rdin);
    chk({tag, "_busy"}, busy, m_busy);
    chk({tag, "_read_req"}, bus.o_read_req, rr);
    chk({tag, "_read_addr"}, bus.o_read_addr, rr ? addr[g] : 32'h0);
    chk({tag, "_write_en"}, bus.o_write_enable, ww);
    chk({tag, "_byte_en"}, bus.o_byte_enable, ww ? be[g] : 4'h0);
    chk({tag, "_write_addr"}, bus.o_write_addr, ww ? addr[g] : 32'h0);
    chk({tag, "_write_data"}, bus.o_write_data, ww ? wdata[g] : 32'h0);
    @(posedge clk);
    if (rst_n) begin
      if (m_busy) m_busy = 0;
      else if (g >= 0) begin
        if (g != 0) m_last = g;
        if (!we[g]) begin m_busy = 1; m_owner = g; end
      end
    end
    #1;
  endtask

  initial begin
    clr(); rdin = 0;
    apply();
    @(posedge clk); #1;
    cyc("reset");
    req[1] = 1;
    cyc("reset_req");
    rst_n = 1;
    // loader write wins while if is ineligible
    clr(); req[0] = 1; we[0] = 1; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF; be[0] = 4'hF; req[1] = 1;
    cyc("t25");
    // loader read, data one cycle later
    clr(); req[0] = 1; addr[0] = 32'h10; rdin = 32'hDEADBEEF;
    cyc("t26_issue");
    clr();
    cyc("t26_data");
    // if/dm both streaming reads
    booted = 1;
    clr(); req[1] = 1; req[2] = 1; addr[1] = 32'h100; addr[2] = 32'h200;
    for (int i = 0; i < 8; i++) begin rdin = $urandom; cyc("t27"); end
    // loader ignored after boot
    clr(); req[0] = 1; addr[0] = 32'h44;
    for (int i = 0; i < 20; i++) cyc("t28");
    // dm back-to-back writes
    for (int i = 0; i < 3; i++) begin
      clr(); req[2] = 1; we[2] = 1; be[2] = 4'(i + 1); addr[2] = 32'h300 + 32'(i); wdata[2] = $urandom;
      cyc("t30");
    end
    // read aborted by reset, then the first tie goes to if
    clr(); req[1] = 1; addr[1] = 32'h55;
    cyc("t29_issue");
    rst_n = 0;
    cyc("t29_rst");
    rst_n = 1;
    clr(); req[1] = 1; req[2] = 1; addr[1] = 32'h66; addr[2] = 32'h77;
    cyc("t29_tie");
    cyc("t29_tie_data");
    // eligibility switch during an outstanding read
    clr(); req[1] = 1; addr[1] = 32'h88;
    cyc("bt_issue");
    booted = 0; req[0] = 1; we[0] = 1; be[0] = 4'h3; addr[0] = 32'h99; wdata[0] = 32'h1234;
    cyc("bt_wait");
    cyc("bt_bl");
    for (int n = 0; n < 400; n++) begin
      booted = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 40) != 0;
      rdin = $urandom;
      for (int i = 0; i < 3; i++) begin
        req[i] = $urandom_range(0, 2) != 0; we[i] = $urandom_range(0, 1) != 0;
        be[i] = 4'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
      end
      cyc("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
